prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Upstream boot stage for the 9-bit core. Accepts a byte stream over a valid/ready
//   handshake and packs each pair of bytes into one 9-bit machine-code word.
//   Writes the words in order into the instruction memory that feeds instr_ROM.
//   Holds the core in reset until PROG_LEN words are written, then releases it.
// PARAMETERS
//   D        12   instruction address width; matches the program counter width
//   W        9    machine-code word width; fixed at 9, bytes-per-word logic assumes W<=16
//   PROG_LEN 319  number of words per load; must be >=1 and <=2**D
// PORTS
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-low reset
//   start       in   1  one-cycle load request
//   in_valid    in   1  byte stream valid
//   in_data     in   8  byte stream data
//   in_ready    out  1  loader accepts a byte this cycle
//   wr_en       out  1  instruction-memory write strobe
//   wr_addr     out  D  instruction-memory write address
//   wr_data     out  W  instruction-memory write data (mach_code image)
//   core_reset  out  1  1 = hold core (PC, flags) in reset
//   busy        out  1  load in progress
//   load_done   out  1  level; full program loaded, core released
//   fmt_err     out  1  sticky; a high byte had nonzero bits [7:1]
// BEHAVIOUR
//   Reset (reset==0, async) forces:
//     - state=IDLE; wr_addr=0; wr_data=0.
//     - in_ready=0, wr_en=0, busy=0, load_done=0, fmt_err=0; core_reset=1.
//     - Instruction memory is not cleared.
//   Byte transfer occurs on a rising edge with in_valid&in_ready; in_ready is
//   independent of in_valid (no combinational path from in_valid).
//   FSM states:
//     IDLE : in_ready=0. start -> LO with wr_addr=0, fmt_err=0.
//     LO   : in_ready=1, busy=1. On transfer, latch in_data as word[7:0] -> HI.
//     HI   : in_ready=1, busy=1. On transfer, word[8]=in_data[0].
//            If in_data[7:1]!=0, set fmt_err; the word is still written. -> WR.
//     WR   : in_ready=0, busy=1, wr_en=1 for exactly one cycle with wr_addr/wr_data valid.
//            If wr_addr==PROG_LEN-1 -> DONE, else wr_addr+=1 -> LO.
//     DONE : load_done=1, core_reset=0, busy=0. start -> LO, wr_addr=0, fmt_err=0,
//            load_done=0, core_reset=1 (reload).
//   core_reset is 1 in every state except DONE.
//   Latency:
//     - wr_en asserts the cycle after the high-byte transfer.
//     - Back-to-back streaming gives 1 word per 3 cycles.
//     - load_done rises the cycle after the last wr_en.
//   Timing and boundary rules:
//     - start is ignored in LO/HI/WR.
//     - start arriving with in_valid in IDLE/DONE: no byte is taken that cycle.
//     - Stalls: in_valid low in LO/HI holds state indefinitely; no timeout.
//     - wr_addr never wraps: it stops at PROG_LEN-1. Extra bytes after DONE are not
//       accepted (in_ready=0).
//     - Reset mid-load: partial word discarded and already written words are left
//       in memory; a new start is required.
//     - wr_data holds the last written word between writes.
// TESTING
//   1. Reset low, then high, no start -> in_ready=0, core_reset=1, load_done=0, wr_en=0.
//   2. PROG_LEN=4, start, stream 0x2A,0x01 -> one wr_en pulse, addr 0, data 9'h12A,
//      asserted the cycle after the 2nd byte.
//   3. Full load of 4 words, back-to-back -> addrs 0..3, wr_en on cycles 3,6,9,12;
//      load_done=1 and core_reset=0 on cycle 13.
//   4. High byte 0x03 -> word bit8=1, fmt_err=1 and stays 1 through DONE;
//      cleared by the next start.
//   5. in_valid toggled randomly, plus a start pulse during HI -> the start has no
//      effect; words and addresses match the stream order exactly.
//   6. reset pulsed low after word 2 of 4 -> core_reset=1, addr 0, IDLE; a reload
//      rewrites addrs 0..3 correctly.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// prog_loader : packs byte pairs from a valid/ready stream into W-bit words,
//               writes them into instruction memory, then releases core reset.
// Revision    : 1.0
// ============================================================================
module prog_loader #(
  parameter int D        = 12,
  parameter int W        = 9,
  parameter int PROG_LEN = 319
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         core_reset,
  output logic         busy,
  output logic         load_done,
  output logic         fmt_err
);

  localparam int           HB      = W - 8;
  localparam logic [7:0]   C_HI_OK = 8'((1 << HB) - 1);
  localparam logic [D-1:0] C_LAST  = D'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_lo;
  logic       w_xfer;

  // in_ready is a register, so acceptance never depends combinationally on in_valid
  assign w_xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_lo       <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      fmt_err    <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= LO;
            wr_addr    <= '0;
            fmt_err    <= 1'b0;
            load_done  <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        LO: begin
          if (w_xfer) begin
            r_lo    <= in_data;
            r_state <= HI;
          end
        end
        HI: begin
          if (w_xfer) begin
            wr_data  <= {in_data[HB-1:0], r_lo};
            // malformed high byte is flagged but the word is still written
            if (|(in_data & ~C_HI_OK)) fmt_err <= 1'b1;
            in_ready <= 1'b0;
            wr_en    <= 1'b1;
            r_state  <= WR;
          end
        end
        WR: begin
          wr_en <= 1'b0;
          if (wr_addr == C_LAST) begin
            r_state    <= DONE;
            load_done  <= 1'b1;
            core_reset <= 1'b0;
            busy       <= 1'b0;
          end else begin
            wr_addr  <= wr_addr + D'(1);
            in_ready <= 1'b1;
            r_state  <= LO;
          end
        end
        default: begin
          r_state  <= IDLE;
          in_ready <= 1'b0;
          wr_en    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_prog_loader : self-checking bench for prog_loader with PROG_LEN=4.
// Revision       : 1.0
// ============================================================================
module tb_prog_loader;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, core_reset, busy, load_done, fmt_err;
  logic [11:0] wr_addr;
  logic [8:0]  wr_data;

  prog_loader #(.D(12), .W(9), .PROG_LEN(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .busy(busy), .load_done(load_done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    int         word;
    bit         err;
  } vec_t;

  typedef struct {
    int addr;
    int data;
    int rel;
  } wr_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t0 = 0;
  wr_t  wq[$];
  logic [7:0] los[PL];
  logic [7:0] his[PL];
  vec_t tab[8];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data), cyc - t0});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 0, 1);
  endtask

  // Loads los/his; optionally holds in_valid with the start pulse and pokes start in HI.
  task automatic run_load(input int max_gap, input int start_hi_at, input bit start_with_valid);
    int  done_rel;
    int  exp_word;
    bit  exp_err;
    wq.delete();
    if (start_with_valid) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
    end
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_core_reset", core_reset, 1);
    chk("start_fmt_err_clear", fmt_err, 0);
    chk("start_load_done_clear", load_done, 0);
    for (int i = 0; i < PL; i++) begin
      send_byte(los[i], max_gap);
      if (i == start_hi_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_hi_busy", busy, 1);
        chk("start_in_hi_ready", in_ready, 1);
        chk("start_in_hi_addr", int'(wr_addr), i);
      end
      send_byte(his[i], max_gap);
    end
    done_rel = -1;
    for (int k = 0; k < 20 && done_rel < 0; k++) begin
      if (load_done) done_rel = cyc - t0;
      else tick();
    end
    chk("wr_count", wq.size(), PL);
    exp_err = 1'b0;
    for (int i = 0; i < PL; i++) begin
      exp_word = (int'(his[i]) % 2) * 256 + int'(los[i]);
      if (his[i] > 8'd1) exp_err = 1'b1;
      if (i < wq.size()) begin
        chk("wr_addr", wq[i].addr, i);
        chk("wr_data", wq[i].data, exp_word);
        if (max_gap == 0 && start_hi_at < 0) chk("wr_cycle", wq[i].rel, 3 * (i + 1));
      end
    end
    if (max_gap == 0 && start_hi_at < 0) chk("done_cycle", done_rel, 3 * PL + 1);
    chk("done_load_done", load_done, 1);
    chk("done_core_reset", core_reset, 0);
    chk("done_busy", busy, 0);
    chk("done_in_ready", in_ready, 0);
    chk("done_fmt_err", fmt_err, int'(exp_err));
    chk("wr_data_hold", int'(wr_data), (int'(his[PL-1]) % 2) * 256 + int'(los[PL-1]));
  endtask

  initial begin
    // table: lo, hi, expected word, expected error contribution
    tab[0] = '{8'h2A, 8'h01, 9'h12A, 1'b0};
    tab[1] = '{8'hFF, 8'h00, 9'h0FF, 1'b0};
    tab[2] = '{8'h00, 8'h01, 9'h100, 1'b0};
    tab[3] = '{8'h55, 8'h00, 9'h055, 1'b0};
    tab[4] = '{8'h10, 8'h03, 9'h110, 1'b1};
    tab[5] = '{8'hA5, 8'h00, 9'h0A5, 1'b0};
    tab[6] = '{8'h5A, 8'h01, 9'h15A, 1'b0};
    tab[7] = '{8'h81, 8'h00, 9'h081, 1'b0};

    // reset state
    repeat (3) tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_data", int'(wr_data), 0);
    #2 reset = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("idle_in_ready", in_ready, 0);
    chk("idle_core_reset", core_reset, 1);
    chk("idle_load_done", load_done, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_busy", busy, 0);
    chk("idle_fmt_err", fmt_err, 0);
    chk("idle_wr_addr", int'(wr_addr), 0);
    chk("idle_wr_count", wq.size(), 0);

    // table-driven back-to-back loads, two loads of four words each
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < PL; i++) begin
        los[i] = tab[l*PL+i].lo;
        his[i] = tab[l*PL+i].hi;
      end
      run_load(0, -1, l == 0);
      for (int i = 0; i < PL && i < wq.size(); i++)
        chk("tab_word", wq[i].data, tab[l*PL+i].word);
      chk("tab_err", fmt_err, int'(tab[l*PL].err | tab[l*PL+1].err | tab[l*PL+2].err | tab[l*PL+3].err));
      // extra bytes after DONE are refused
      wq.delete();
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (4) tick();
      in_valid = 1'b0;
      chk("after_done_no_write", wq.size(), 0);
      chk("after_done_ready", in_ready, 0);
      chk("after_done_load_done", load_done, 1);
    end

    // randomized stalls, random bytes, occasional start pulse in HI
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < PL; i++) begin
        los[i] = 8'($urandom);
        his[i] = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(1, 0));
      end
      run_load(3, (r % 2 == 0) ? int'($urandom_range(PL-1, 0)) : -1, 1'b0);
    end

    // reset mid-load after two words, then a clean reload
    for (int i = 0; i < PL; i++) begin
      los[i] = 8'(8'h30 + i);
      his[i] = 8'(i % 2);
    end
    wq.delete();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_byte(los[i], 0);
      send_byte(his[i], 0);
    end
    tick();
    chk("midload_writes", wq.size(), 2);
    #2 reset = 1'b0;
    #1;
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_wr_addr", int'(wr_addr), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_wr_en", wr_en, 0);
    repeat (2) tick();
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("postrst_idle_ready", in_ready, 0);
    chk("postrst_idle_busy", busy, 0);
    for (int i = 0; i < PL; i++) begin
      los[i] = 8'(8'hC0 + i);
      his[i] = 8'((i + 1) % 2);
    end
    run_load(0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
